// File: rtl/cmd_data_sorter_pkg.sv
// Shared definitions for the command/data packet sorter.
// Holds the FSM encoding, the default reset opcode and the opcode field geometry.
// No logic lives here. Flow control and latency belong to the modules that import it.
package cod_pkg;

   // Packet classification state: idle between packets, or inside a command or data packet
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CMD  = 2'd1,
      ST_DATA = 2'd2
   } state_e;

   // Opcode occupies the top OPC_W bits of the assembled command word
   localparam int            OPC_W          = 8;
   localparam logic [OPC_W-1:0] RST_OPCODE_DEF = 8'h00;

endpackage

// File: rtl/cmd_data_sorter_if.sv
// Bundle of the receive-side beat inputs and the sorted outputs of cmd_data_sorter.
// Wiring only, so there is no latency.
// No backpressure: the producer drives beats whenever data_valid is high.
interface cmd_data_sorter_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 9,
   parameter int LEN_W  = 16,
   parameter int CMD_W  = 64
);
   logic [DATA_W-1:0] data;
   logic [ADDR_W-1:0] wr_ddr;
   logic [LEN_W-1:0]  data_length;
   logic [LEN_W-1:0]  total_length;
   logic              data_valid;
   logic              data_sof;
   logic              data_eof;

   logic [DATA_W-1:0] rx_data;
   logic [ADDR_W-1:0] ram_wr_ddr;
   logic              data_o_valid;
   logic [LEN_W-1:0]  data_o_length;
   logic [LEN_W-1:0]  total_o_length;
   logic              cmd_o_valid;
   logic [CMD_W-1:0]  cmd_o_word;
   logic              cmd_err;
   logic              reset;

   // Receive parser side: drives beats and observes the sorter results
   modport master (
      output data, wr_ddr, data_length, total_length, data_valid, data_sof, data_eof,
      input  rx_data, ram_wr_ddr, data_o_valid, data_o_length, total_o_length,
      input  cmd_o_valid, cmd_o_word, cmd_err, reset
   );

   // Sorter side
   modport slave (
      input  data, wr_ddr, data_length, total_length, data_valid, data_sof, data_eof,
      output rx_data, ram_wr_ddr, data_o_valid, data_o_length, total_o_length,
      output cmd_o_valid, cmd_o_word, cmd_err, reset
   );
endinterface

// File: rtl/cmd_data_sorter_rst_pulse_gen.sv
// Stretches a one-cycle trigger into a reset pulse exactly RST_CYC cycles wide.
// The pulse rises on the cycle after the trigger edge.
// Triggers arriving while a pulse is active are ignored, so the pulse is never extended.
module rst_pulse_gen #(
   parameter int RST_CYC = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic trig_i,
   output logic busy_o,
   output logic reset_o
);
   localparam int CW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

   logic [CW-1:0] cnt_q, cnt_d;
   logic          pulse_q, pulse_d;

   // Load the remaining-cycle count on an idle trigger, then count down to release
   always_comb begin
      cnt_d   = cnt_q;
      pulse_d = pulse_q;
      if (pulse_q) begin
         if (cnt_q == '0) begin
            pulse_d = 1'b0;
         end else begin
            cnt_d = cnt_q - CW'(1);
         end
      end else if (trig_i) begin
         pulse_d = 1'b1;
         cnt_d   = CW'(RST_CYC - 1);
      end
   end

   // Pulse state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q   <= '0;
         pulse_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         pulse_q <= pulse_d;
      end
   end

   assign busy_o  = pulse_q;
   assign reset_o = pulse_q;
endmodule

// File: rtl/cmd_data_sorter.sv
// Sorts received packets into data beats for the RAM write path and assembled command words.
// Data beats appear 1 cycle after input. Command strobes appear 1 cycle after the eof beat.
// No backpressure: every valid beat is consumed in the cycle it is presented.
module cmd_data_sorter
   import cod_pkg::*;
#(
   parameter int               DATA_W        = 32,
   parameter int               ADDR_W        = 9,
   parameter int               LEN_W         = 16,
   parameter int               CMD_WORDS     = 2,
   parameter int               CMD_DATA_LEN  = 16,
   parameter int               CMD_TOTAL_LEN = 36,
   parameter logic [OPC_W-1:0] RST_OPCODE    = RST_OPCODE_DEF,
   parameter int               RST_CYC       = 4
) (
   input  logic              clk,
   input  logic              rst,
   cmd_data_sorter_if.slave  bus
);
   localparam int CMD_W = CMD_WORDS * DATA_W;
   // The counter must be able to hold CMD_WORDS+1 so that over-long commands are detected
   localparam int CNT_W = $clog2(CMD_WORDS + 2);

   state_e            state_q, state_d;
   logic [DATA_W-1:0] rx_q, rx_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              dvld_q, dvld_d;
   logic [LEN_W-1:0]  dlen_q, dlen_d;
   logic [LEN_W-1:0]  tlen_q, tlen_d;
   logic [CMD_W-1:0]  shift_q, shift_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              cvld_q, cvld_d;
   logic [CMD_W-1:0]  cword_q, cword_d;
   logic              cerr_q, cerr_d;

   state_e            cls;
   logic              is_cmd;
   logic [CMD_W-1:0]  shift_base, shift_nxt;
   logic [CNT_W-1:0]  cnt_base, cnt_nxt;
   logic              rst_match, rst_busy;

   // A sof beat starts a fresh command, so the assembly state restarts from zero
   assign is_cmd     = (bus.data_length == LEN_W'(CMD_DATA_LEN)) ||
                       (bus.total_length == LEN_W'(CMD_TOTAL_LEN));
   assign shift_base = bus.data_sof ? '0 : shift_q;
   assign cnt_base   = bus.data_sof ? '0 : cnt_q;
   assign shift_nxt  = (shift_base << DATA_W) | CMD_W'(bus.data);
   assign cnt_nxt    = (cnt_base == CNT_W'(CMD_WORDS + 1)) ? cnt_base : cnt_base + CNT_W'(1);

   // Classify the beat, route it to the data or command path and compute the next FSM state
   always_comb begin
      state_d   = state_q;
      rx_d      = rx_q;
      addr_d    = addr_q;
      dvld_d    = 1'b0;
      dlen_d    = dlen_q;
      tlen_d    = tlen_q;
      shift_d   = shift_q;
      cnt_d     = cnt_q;
      cvld_d    = 1'b0;
      cword_d   = cword_q;
      cerr_d    = 1'b0;
      rst_match = 1'b0;
      cls       = state_q;
      if (bus.data_valid) begin
         if (bus.data_sof) begin
            // A sof beat inside an open command means its eof never came
            cerr_d = (state_q == ST_CMD);
            cls    = is_cmd ? ST_CMD : ST_DATA;
         end
         case (cls)
            ST_DATA: begin
               rx_d   = bus.data;
               addr_d = bus.wr_ddr;
               dvld_d = 1'b1;
               if (bus.data_sof) begin
                  dlen_d = bus.data_length;
                  tlen_d = bus.total_length;
               end
               state_d = bus.data_eof ? ST_IDLE : ST_DATA;
            end
            ST_CMD: begin
               shift_d = shift_nxt;
               cnt_d   = cnt_nxt;
               state_d = ST_CMD;
               if (bus.data_eof) begin
                  if (cnt_nxt == CNT_W'(CMD_WORDS)) begin
                     cvld_d    = 1'b1;
                     cword_d   = shift_nxt;
                     rst_match = (shift_nxt[CMD_W-1 -: OPC_W] == RST_OPCODE);
                  end else begin
                     cerr_d = 1'b1;
                  end
                  cnt_d   = '0;
                  state_d = ST_IDLE;
               end
            end
            default: begin
               // Beat outside any packet: dropped
            end
         endcase
      end
   end

   // Sorter state and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         rx_q    <= '0;
         addr_q  <= '0;
         dvld_q  <= 1'b0;
         dlen_q  <= '0;
         tlen_q  <= '0;
         shift_q <= '0;
         cnt_q   <= '0;
         cvld_q  <= 1'b0;
         cword_q <= '0;
         cerr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         rx_q    <= rx_d;
         addr_q  <= addr_d;
         dvld_q  <= dvld_d;
         dlen_q  <= dlen_d;
         tlen_q  <= tlen_d;
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
         cvld_q  <= cvld_d;
         cword_q <= cword_d;
         cerr_q  <= cerr_d;
      end
   end

   // The pulse register updates on the same edge as cvld_q, so reset rises together with cmd_o_valid
   rst_pulse_gen #(.RST_CYC(RST_CYC)) u_rst_pulse (
      .clk     (clk),
      .rst     (rst),
      .trig_i  (rst_match & ~rst_busy),
      .busy_o  (rst_busy),
      .reset_o (bus.reset)
   );

   assign bus.rx_data        = rx_q;
   assign bus.ram_wr_ddr     = addr_q;
   assign bus.data_o_valid   = dvld_q;
   assign bus.data_o_length  = dlen_q;
   assign bus.total_o_length = tlen_q;
   assign bus.cmd_o_valid    = cvld_q;
   assign bus.cmd_o_word     = cword_q;
   assign bus.cmd_err        = cerr_q;
endmodule

// File: tb/tb_cmd_data_sorter.sv
// Bench for cmd_data_sorter: directed scenarios followed by randomized packets.
// Outputs are compared every cycle against a packet-level reference model.
// Inputs are driven 1 time unit after the rising edge, and outputs are sampled at the same point.
module tb_cmd_data_sorter;
   localparam int DATA_W    = 32;
   localparam int ADDR_W    = 9;
   localparam int LEN_W     = 16;
   localparam int CMD_WORDS = 2;
   localparam int CMD_W     = CMD_WORDS * DATA_W;
   localparam int RST_CYC   = 4;
   localparam logic [7:0] RST_OP = 8'h00;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   cmd_data_sorter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .CMD_W(CMD_W)) bus ();

   cmd_data_sorter #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .CMD_WORDS(CMD_WORDS),
      .CMD_DATA_LEN(16), .CMD_TOTAL_LEN(36), .RST_OPCODE(RST_OP), .RST_CYC(RST_CYC)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int n_chk = 0;
   int n_bad = 0;

   // Reference model state: packet class (0 none, 1 command, 2 data), collected command beats
   int                m_cls = 0;
   logic [31:0]       cmdq[$];
   int                m_rst_left = 0;
   logic [31:0]       e_rx;
   logic [ADDR_W-1:0] e_addr;
   logic              e_dvld, e_cvld, e_cerr;
   logic [15:0]       e_dlen, e_tlen;
   logic [63:0]       e_cword;

   logic [31:0]       pkt_q[$];
   logic [ADDR_W-1:0] addr_ctr = '0;
   int                n_pulses = 0;

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h want=%h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_cls = 0;
      cmdq.delete();
      m_rst_left = 0;
      e_rx = '0; e_addr = '0; e_dvld = 0; e_cvld = 0; e_cerr = 0;
      e_dlen = '0; e_tlen = '0; e_cword = '0;
   endtask

   task automatic check_outputs();
      check_eq("data_o_valid", 64'(bus.data_o_valid), 64'(e_dvld));
      check_eq("rx_data", 64'(bus.rx_data), 64'(e_rx));
      check_eq("ram_wr_ddr", 64'(bus.ram_wr_ddr), 64'(e_addr));
      check_eq("data_o_length", 64'(bus.data_o_length), 64'(e_dlen));
      check_eq("total_o_length", 64'(bus.total_o_length), 64'(e_tlen));
      check_eq("cmd_o_valid", 64'(bus.cmd_o_valid), 64'(e_cvld));
      check_eq("cmd_o_word", 64'(bus.cmd_o_word), e_cword);
      check_eq("cmd_err", 64'(bus.cmd_err), 64'(e_cerr));
      check_eq("reset", 64'(bus.reset), 64'(m_rst_left > 0));
   endtask

   // One clock cycle: drive a beat (or idle), advance the model, compare all outputs
   task automatic step(input bit v, input bit s, input bit e, input logic [31:0] d,
                       input logic [ADDR_W-1:0] a, input logic [15:0] dl, input logic [15:0] tl);
      bit          busy;
      logic [63:0] w;
      bus.data_valid = v; bus.data_sof = s; bus.data_eof = e; bus.data = d;
      bus.wr_ddr = a; bus.data_length = dl; bus.total_length = tl;
      @(posedge clk);
      e_dvld = 0; e_cvld = 0; e_cerr = 0;
      busy = (m_rst_left > 0);
      if (m_rst_left > 0) m_rst_left--;
      if (v) begin
         if (s) begin
            if (m_cls == 1) e_cerr = 1;
            m_cls = (dl == 16 || tl == 36) ? 1 : 2;
            cmdq.delete();
            if (m_cls == 2) begin e_dlen = dl; e_tlen = tl; end
         end
         if (m_cls == 2) begin
            e_dvld = 1; e_rx = d; e_addr = a;
            if (e) m_cls = 0;
         end else if (m_cls == 1) begin
            cmdq.push_back(d);
            if (e) begin
               if (cmdq.size() == CMD_WORDS) begin
                  w = '0;
                  foreach (cmdq[i]) w = (w << DATA_W) | 64'(cmdq[i]);
                  e_cvld = 1; e_cword = w;
                  if (w[63:56] == RST_OP && !busy) begin
                     m_rst_left = RST_CYC;
                     n_pulses++;
                  end
               end else begin
                  e_cerr = 1;
               end
               m_cls = 0;
               cmdq.delete();
            end
         end
      end
      #1;
      check_outputs();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, $urandom, ADDR_W'($urandom), 16'($urandom), 16'($urandom));
   endtask

   // Sends pkt_q as one packet; with_eof=0 leaves the packet open
   task automatic send_pkt(input logic [15:0] dl, input logic [15:0] tl, input bit with_eof);
      for (int i = 0; i < pkt_q.size(); i++) begin
         step(1, i == 0, with_eof && (i == pkt_q.size() - 1), pkt_q[i], addr_ctr, dl, tl);
         addr_ctr++;
      end
   endtask

   task automatic pulse_rst();
      rst = 1'b1;
      #2;
      model_reset();
      check_outputs();
      rst = 1'b0;
   endtask

   initial begin
      logic [31:0] r;
      logic [7:0]  op;
      model_reset();
      bus.data_valid = 0; bus.data_sof = 0; bus.data_eof = 0; bus.data = '0;
      bus.wr_ddr = '0; bus.data_length = '0; bus.total_length = '0;
      repeat (2) @(posedge clk);
      #1;
      check_outputs();
      rst = 1'b0;
      idle(2);

      // Data packet of four beats
      pkt_q = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
      send_pkt(16'd1024, 16'd1052, 1);
      idle(2);
      // Reset command
      pkt_q = '{32'h0011_2233, 32'h4455_6677};
      send_pkt(16'd16, 16'd44, 1);
      idle(6);
      check_eq("pulses_after_rst_cmd", 64'(n_pulses), 64'd1);
      // Non-reset command
      pkt_q = '{32'h0100_0000, 32'h0};
      send_pkt(16'd16, 16'd44, 1);
      idle(6);
      // Too long, then too short
      pkt_q = '{32'h1, 32'h2, 32'h3};
      send_pkt(16'd16, 16'd44, 1);
      pkt_q = '{32'h4};
      send_pkt(16'd8, 16'd36, 1);
      idle(6);
      // Back-to-back reset commands, then one more after the pulse
      pkt_q = '{32'h00AB_0000, 32'h1};
      send_pkt(16'd16, 16'd44, 1);
      send_pkt(16'd16, 16'd44, 1);
      idle(8);
      send_pkt(16'd16, 16'd44, 1);
      idle(6);
      check_eq("pulses_after_triple", 64'(n_pulses), 64'd3);
      // Reset asserted in the middle of a command
      step(1, 1, 0, 32'h0000_0001, addr_ctr, 16'd16, 16'd44);
      pulse_rst();
      pkt_q = '{32'h0055_6677, 32'h8899_AABB};
      send_pkt(16'd16, 16'd44, 1);
      idle(6);
      // Back-to-back data packets, a single-beat data packet, and a missing eof
      pkt_q = '{32'hD0, 32'hD1};
      send_pkt(16'd200, 16'd228, 1);
      pkt_q = '{32'hD2};
      send_pkt(16'd300, 16'd328, 1);
      pkt_q = '{32'h00C0_0000};
      send_pkt(16'd16, 16'd44, 0);
      pkt_q = '{32'hD3, 32'hD4};
      send_pkt(16'd400, 16'd428, 1);
      idle(6);

      // Randomized packets
      for (int p = 0; p < 300; p++) begin
         int  n;
         bit  miss;
         logic [15:0] dl, tl;
         miss = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 5) == 0)
            step(1, 0, 1'($urandom), $urandom, ADDR_W'($urandom), 16'($urandom), 16'($urandom));
         pkt_q.delete();
         if ($urandom_range(0, 1) == 0) begin
            n  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 2;
            dl = ($urandom_range(0, 1) == 0) ? 16'd16 : 16'($urandom_range(40, 100));
            tl = (dl == 16'd16) ? 16'($urandom_range(40, 100)) : 16'd36;
            for (int i = 0; i < n; i++) begin
               r  = $urandom;
               op = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
               pkt_q.push_back((i == 0) ? {op, r[23:0]} : r);
            end
         end else begin
            n  = $urandom_range(1, 4);
            dl = 16'($urandom_range(17, 2000));
            tl = dl + 16'd20;
            for (int i = 0; i < n; i++) pkt_q.push_back($urandom);
         end
         send_pkt(dl, tl, !miss);
         if ($urandom_range(0, 40) == 0) pulse_rst();
         idle($urandom_range(0, 2));
      end
      idle(8);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule

// File: doc/cmd_data_sorter.md
# cmd_data_sorter

Parametrised packet sorter sitting between the UDP/Ethernet receive parser and the DDR write buffer. Classifies each received packet as command or data from its length fields, forwards data beats to the RAM write path with one-cycle latency, and assembles command packets into a wide command word. Decodes a programmable reset opcode into a stretched system reset pulse; re-triggering within an active pulse is ignored. Adds explicit packet framing, multi-word commands and malformed-command detection.

## Interface
- DATA_W, 32, data beat width
- ADDR_W, 9, RAM write address width
- LEN_W, 16, length field width
- CMD_WORDS, 2, beats per command packet (≥1); command word width CMD_W = CMD_WORDS*DATA_W
- CMD_DATA_LEN, 16, data_length value marking a command packet
- CMD_TOTAL_LEN, 36, total_length value marking a command packet
- RST_OPCODE, 8'h00, opcode (command bits [CMD_W-1:CMD_W-8]) requesting reset
- RST_CYC, 4, reset pulse width in cycles (≥1)

- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- data  in  DATA_W  received beat
- wr_ddr  in  ADDR_W  RAM write address for the beat
- data_length  in  LEN_W  payload length of current packet
- total_length  in  LEN_W  total length of current packet
- data_valid  in  1  beat qualifier
- data_sof  in  1  first beat of packet (qualified by data_valid)
- data_eof  in  1  last beat of packet (qualified by data_valid; may coincide with sof)
- rx_data  out  DATA_W  forwarded data beat
- ram_wr_ddr  out  ADDR_W  forwarded address
- data_o_valid  out  1  forwarded beat strobe
- data_o_length  out  LEN_W  data_length of last data packet
- total_o_length  out  LEN_W  total_length of last data packet
- cmd_o_valid  out  1  one-cycle strobe, well-formed command
- cmd_o_word  out  CMD_W  assembled command, first beat in MSBs
- cmd_err  out  1  one-cycle strobe, malformed command
- reset  out  1  stretched system reset pulse

## Operation
- FSM: IDLE, CMD, DATA. Classification decided only on sof beat: command if data_length==CMD_DATA_LEN or total_length==CMD_TOTAL_LEN, else data.
- IDLE: valid beat without sof dropped silently. sof beat → CMD or DATA; beat processed in that class.
- DATA: each valid beat → rx_data<=data, ram_wr_ddr<=wr_ddr, data_o_valid=1. On sof beat data_o_length/total_o_length latched; held otherwise. eof → IDLE.
- CMD: each valid beat shifted into shift register (new beat enters LSBs); beat counter saturates at CMD_WORDS+1. Nothing on data outputs; data_o_length/total_o_length unchanged.
- On eof in CMD: count==CMD_WORDS → cmd_o_valid=1, cmd_o_word=shift register contents; otherwise cmd_err=1, cmd_o_word unchanged. → IDLE.
- sof while in CMD or DATA (missing eof): open command aborted with cmd_err; new packet classified normally in same cycle.
- Reset decode: on cmd_o_valid with opcode==RST_OPCODE and pulse inactive → reset high for exactly RST_CYC cycles. Matching command during active pulse ignored (no extension).
- Reset values: all outputs 0, FSM IDLE, counters 0.

## Timing
- Data path latency 1 cycle: beat at edge N → data_o_valid at N+1.
- cmd_o_valid/cmd_err asserted cycle after eof beat, one cycle wide.
- reset rises same cycle as triggering cmd_o_valid; falls after RST_CYC cycles.
- Back-to-back packets (eof then sof next cycle, or eof+sof-single-beat) fully supported, no bubble.
- rst asserted mid-packet: FSM → IDLE, partial command discarded, no strobes, active reset pulse terminated.

## Structure
- Package cod_pkg: FSM state encoding, default RST_OPCODE, opcode field position constants.
- Sub-module rst_pulse_gen (trigger in, RST_CYC counter, busy/reset out); rest flat.

## Test plan
- Data packet, data_length=1024, 4 beats 0xA0..0xA3 → data_o_valid 4 cycles, rx_data 0xA0..0xA3 one cycle late, data_o_length=1024.
- Command data_length=16, beats 0x00112233, 0x44556677 → cmd_o_valid 1 cycle, cmd_o_word=0x0011223344556677, reset high 4 cycles.
- Command 0x01000000, 0x0 → cmd_o_valid, reset stays 0; data_o_length unchanged from prior data packet.
- Command with 3 beats, then command with 1 beat → cmd_err twice, no cmd_o_valid, no reset.
- Two reset commands 2 cycles apart → single 4-cycle reset pulse; third after pulse ends → new pulse.
- rst pulsed after first command beat, then new sof → no strobes, fresh command assembles correctly.
